// File: rtl/pupil_track_ctrl.sv
// pupil_track_ctrl
// Tracks the pupil as the centroid of dark pixels in each video frame and
// positions a square overlay box centred on it.
//
// Ports:
//   iCLK            pixel clock
//   iRST            asynchronous active-low reset
//   iDVAL           pixel-valid qualifier
//   iH_Cont/iV_Cont current pixel column / row (13 bits)
//   iGray           grayscale pixel value (10 bits)
//   oBoxX/oBoxY     overlay box top-left corner
//   oValid          1-cycle pulse when the box position is updated
//   oLost           level, last evaluated frame had too few dark pixels
//   oBusy           level, a frame result is being processed
//   oDrop           1-cycle pulse when a frame ends while still processing
module pupil_track_ctrl #(
    parameter logic [9:0]  THRESH    = 10'd100,
    parameter logic [12:0] BOX       = 13'd40,
    parameter logic [19:0] MIN_COUNT = 20'd64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic [9:0]  iGray,
    output logic [12:0] oBoxX,
    output logic [12:0] oBoxY,
    output logic        oValid,
    output logic        oLost,
    output logic        oBusy,
    output logic        oDrop
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_DIVX   = 3'd2;
    localparam logic [2:0] S_DIVY   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic [12:0] HALF_BOX = BOX >> 1;
    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;
    localparam logic [5:0]  LAST_STEP = 6'd32;

    logic [12:0] r_prevV;
    logic [19:0] r_cnt;
    logic [32:0] r_sumX;
    logic [32:0] r_sumY;
    logic [19:0] r_snapCnt;
    logic [32:0] r_snapX;
    logic [32:0] r_snapY;
    logic [2:0]  r_state;
    logic [32:0] r_quot;
    logic [19:0] r_rem;
    logic [5:0]  r_step;
    logic [12:0] r_qX;
    logic [12:0] r_qY;
    logic [12:0] r_boxX;
    logic [12:0] r_boxY;
    logic        r_valid;
    logic        r_lost;
    logic        r_drop;

    logic        w_frameEnd;
    logic        w_dark;
    logic [19:0] w_cntInc;
    logic [32:0] w_hExt;
    logic [32:0] w_vExt;
    logic [20:0] w_remShift;
    logic        w_fits;
    logic [19:0] w_diff;
    logic [19:0] w_remNext;
    logic [32:0] w_quotNext;
    logic        w_lastStep;
    logic [12:0] w_boxX;
    logic [12:0] w_boxY;

    // A frame ends when the row counter wraps back towards the top.
    assign w_frameEnd = (iV_Cont < r_prevV);
    assign w_dark     = iDVAL && (iGray < THRESH);
    assign w_cntInc   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + 20'd1);
    assign w_hExt     = {20'd0, iH_Cont};
    assign w_vExt     = {20'd0, iV_Cont};

    // One restoring-division step: shift the next dividend bit (MSB of the
    // quotient register) into the remainder and subtract if it fits. The
    // quotient bits fill the vacated LSBs, so after 33 steps r_quot holds
    // the full quotient. A successful subtraction always leaves a value
    // below the divisor, so 20 bits of difference are enough.
    assign w_remShift = {r_rem, r_quot[32]};
    assign w_fits     = (w_remShift >= {1'b0, r_snapCnt});
    assign w_diff     = w_remShift[19:0] - r_snapCnt;
    assign w_remNext  = w_fits ? w_diff : w_remShift[19:0];
    assign w_quotNext = {r_quot[31:0], w_fits};
    assign w_lastStep = (r_step == LAST_STEP);

    // Centre the box on the centroid, clamping at the image edge.
    assign w_boxX = (r_qX < HALF_BOX) ? 13'd0 : (r_qX - HALF_BOX);
    assign w_boxY = (r_qY < HALF_BOX) ? 13'd0 : (r_qY - HALF_BOX);

    assign oBoxX  = r_boxX;
    assign oBoxY  = r_boxY;
    assign oValid = r_valid;
    assign oLost  = r_lost;
    assign oDrop  = r_drop;
    assign oBusy  = (r_state != S_IDLE);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_prevV <= 13'd0;
        end else begin
            r_prevV <= iV_Cont;
        end
    end

    // The pixel on the frame-end cycle belongs to the new frame, so it
    // seeds the accumulators instead of being added to the old totals.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_cnt  <= 20'd0;
            r_sumX <= 33'd0;
            r_sumY <= 33'd0;
        end else if (w_frameEnd) begin
            r_cnt  <= w_dark ? 20'd1 : 20'd0;
            r_sumX <= w_dark ? w_hExt : 33'd0;
            r_sumY <= w_dark ? w_vExt : 33'd0;
        end else if (w_dark) begin
            r_cnt  <= w_cntInc;
            r_sumX <= r_sumX + w_hExt;
            r_sumY <= r_sumY + w_vExt;
        end
    end

    // A frame end outside IDLE only discards the totals; the running
    // division keeps its own snapshot and is not disturbed.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state   <= S_IDLE;
            r_snapCnt <= 20'd0;
            r_snapX   <= 33'd0;
            r_snapY   <= 33'd0;
            r_quot    <= 33'd0;
            r_rem     <= 20'd0;
            r_step    <= 6'd0;
            r_qX      <= 13'd0;
            r_qY      <= 13'd0;
            r_boxX    <= 13'd0;
            r_boxY    <= 13'd0;
            r_valid   <= 1'b0;
            r_lost    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_drop  <= w_frameEnd && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_frameEnd) begin
                        r_snapCnt <= r_cnt;
                        r_snapX   <= r_sumX;
                        r_snapY   <= r_sumY;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_snapCnt < MIN_COUNT) begin
                        r_lost  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_quot  <= r_snapX;
                        r_rem   <= 20'd0;
                        r_step  <= 6'd0;
                        r_state <= S_DIVX;
                    end
                end
                S_DIVX: begin
                    if (w_lastStep) begin
                        r_qX    <= w_quotNext[12:0];
                        r_quot  <= r_snapY;
                        r_rem   <= 20'd0;
                        r_step  <= 6'd0;
                        r_state <= S_DIVY;
                    end else begin
                        r_quot <= w_quotNext;
                        r_rem  <= w_remNext;
                        r_step <= r_step + 6'd1;
                    end
                end
                S_DIVY: begin
                    if (w_lastStep) begin
                        r_qY    <= w_quotNext[12:0];
                        r_step  <= 6'd0;
                        r_state <= S_UPDATE;
                    end else begin
                        r_quot <= w_quotNext;
                        r_rem  <= w_remNext;
                        r_step <= r_step + 6'd1;
                    end
                end
                S_UPDATE: begin
                    r_boxX  <= w_boxX;
                    r_boxY  <= w_boxY;
                    r_lost  <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pupil_track_ctrl.sv
// tb_pupil_track_ctrl
// Self-checking bench for pupil_track_ctrl. A frame-level model computes
// centroid results and their schedule from plain arithmetic; a compare
// process checks every output after every clock edge, and directed
// scenarios pin literal box positions and latencies.
module tb_pupil_track_ctrl;

    localparam int THR     = 100;
    localparam int HALF    = 20;
    localparam int MINC    = 64;
    localparam int LATENCY = 68;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iDVAL = 1'b0;
    logic [12:0] iH_Cont = 13'd0;
    logic [12:0] iV_Cont = 13'd0;
    logic [9:0]  iGray = 10'd0;
    logic [12:0] oBoxX;
    logic [12:0] oBoxY;
    logic        oValid;
    logic        oLost;
    logic        oBusy;
    logic        oDrop;

    int checks = 0;
    int errors = 0;

    int edgeCnt = 0;
    int feEdge = 0;
    int lastValidEdge = -1;
    int lastValidX = -1;
    int lastValidY = -1;
    int dropCount = 0;

    // Model state
    longint mCnt = 0;
    longint mSumX = 0;
    longint mSumY = 0;
    int     mPrevV = 0;
    bit     mPending = 0;
    bit     mJobLost = 0;
    int     mJobEnd = 0;
    int     mJobBoxX = 0;
    int     mJobBoxY = 0;
    int     mBoxX = 0;
    int     mBoxY = 0;
    bit     mValid = 0;
    bit     mLost = 0;
    bit     mDrop = 0;
    bit     mBusy = 0;

    pupil_track_ctrl dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDVAL  (iDVAL),
        .iH_Cont(iH_Cont),
        .iV_Cont(iV_Cont),
        .iGray  (iGray),
        .oBoxX  (oBoxX),
        .oBoxY  (oBoxY),
        .oValid (oValid),
        .oLost  (oLost),
        .oBusy  (oBusy),
        .oDrop  (oDrop)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
        end
    endtask

    // Frame-level model: a frame's totals become a job that finishes after a
    // fixed number of edges; frames ending while a job is open are dropped.
    always @(posedge iCLK) begin : model
        bit     fe;
        bit     dark;
        bit     idleBefore;
        longint q;
        edgeCnt++;
        if (!iRST) begin
            mCnt = 0; mSumX = 0; mSumY = 0; mPrevV = 0;
            mPending = 0; mBoxX = 0; mBoxY = 0;
            mValid = 0; mLost = 0; mDrop = 0; mBusy = 0;
        end else begin
            mValid = 0;
            mDrop = 0;
            idleBefore = !mPending;
            if (mPending && edgeCnt == mJobEnd) begin
                if (mJobLost) begin
                    mLost = 1;
                end else begin
                    mValid = 1;
                    mLost = 0;
                    mBoxX = mJobBoxX;
                    mBoxY = mJobBoxY;
                end
                mPending = 0;
            end
            fe = int'(iV_Cont) < mPrevV;
            mPrevV = int'(iV_Cont);
            dark = iDVAL && (int'(iGray) < THR);
            if (fe) begin
                if (idleBefore) begin
                    mPending = 1;
                    if (mCnt < MINC) begin
                        mJobLost = 1;
                        mJobEnd = edgeCnt + 1;
                    end else begin
                        mJobLost = 0;
                        mJobEnd = edgeCnt + LATENCY;
                        q = (mSumX / mCnt) % 8192;
                        mJobBoxX = (q < HALF) ? 0 : int'(q) - HALF;
                        q = (mSumY / mCnt) % 8192;
                        mJobBoxY = (q < HALF) ? 0 : int'(q) - HALF;
                    end
                end else begin
                    mDrop = 1;
                end
                mCnt  = dark ? 1 : 0;
                mSumX = dark ? longint'(iH_Cont) : 0;
                mSumY = dark ? longint'(iV_Cont) : 0;
            end else if (dark) begin
                if (mCnt < 1048575) mCnt = mCnt + 1;
                mSumX = mSumX + longint'(iH_Cont);
                mSumY = mSumY + longint'(iV_Cont);
            end
            mBusy = mPending;
        end
    end

    always @(posedge iCLK) begin : compare
        #2;
        checkOutput("oValid", oValid, mValid);
        checkOutput("oLost", oLost, mLost);
        checkOutput("oBusy", oBusy, mBusy);
        checkOutput("oDrop", oDrop, mDrop);
        checkOutput("oBoxX", oBoxX, mBoxX);
        checkOutput("oBoxY", oBoxY, mBoxY);
        if (oValid === 1'b1) begin
            lastValidEdge = edgeCnt;
            lastValidX = int'(oBoxX);
            lastValidY = int'(oBoxY);
        end
        if (oDrop === 1'b1) dropCount++;
    end

    task automatic applyStimulus(input logic dval, input int h, input int v, input int g);
        @(negedge iCLK);
        iDVAL = dval;
        iH_Cont = 13'(h);
        iV_Cont = 13'(v);
        iGray = 10'(g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, int'(iV_Cont), 1023);
    endtask

    task automatic frameEnd();
        lastValidEdge = -1;
        applyStimulus(1'b0, 0, 0, 1023);
        feEdge = edgeCnt + 1;
    endtask

    // Dark square of side n with a bright pixel after each row.
    task automatic square(input int x0, input int y0, input int n);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) applyStimulus(1'b1, x0 + c, y0 + r, 0);
            applyStimulus(1'b1, x0 + n + 5, y0 + r, 1023);
        end
    endtask

    task automatic expectValid(input string name, input int ex, input int ey);
        idle(LATENCY + 4);
        checkOutput({name, " latency"}, lastValidEdge - feEdge, LATENCY);
        checkOutput({name, " boxX"}, lastValidX, ex);
        checkOutput({name, " boxY"}, lastValidY, ey);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " oBoxX"}, oBoxX, 0);
        checkOutput({name, " oBoxY"}, oBoxY, 0);
        checkOutput({name, " oValid"}, oValid, 0);
        checkOutput({name, " oLost"}, oLost, 0);
        checkOutput({name, " oBusy"}, oBusy, 0);
        checkOutput({name, " oDrop"}, oDrop, 0);
    endtask

    initial begin : stimulus
        int n;
        int v;
        repeat (3) @(negedge iCLK);
        #1;
        checkAllZero("reset");
        @(negedge iCLK);
        iRST = 1'b1;
        idle(3);

        $display("[TB] centred dark square");
        square(100, 200, 10);
        frameEnd();
        expectValid("square", 84, 184);
        checkOutput("square oLost", oLost, 0);

        $display("[TB] all-bright frame");
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 50 + i, 10 + i, 1023);
        frameEnd();
        idle(2);
        checkOutput("bright oBusy", oBusy, 0);
        checkOutput("bright oLost", oLost, 1);
        checkOutput("bright held X", oBoxX, 84);
        checkOutput("bright held Y", oBoxY, 184);
        idle(70);
        checkOutput("bright no valid", lastValidEdge, -1);

        $display("[TB] corner square clamps to zero");
        square(0, 0, 10);
        frameEnd();
        expectValid("corner", 0, 0);
        checkOutput("corner oLost", oLost, 0);

        $display("[TB] frame end during division");
        dropCount = 0;
        square(100, 200, 10);
        frameEnd();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 7000, 5, 0);
        applyStimulus(1'b0, 0, 0, 1023);
        idle(52);
        checkOutput("drop count", dropCount, 1);
        checkOutput("drop first latency", lastValidEdge - feEdge, LATENCY);
        checkOutput("drop first boxX", lastValidX, 84);
        checkOutput("drop first boxY", lastValidY, 184);
        square(300, 50, 10);
        frameEnd();
        expectValid("after drop", 284, 34);

        $display("[TB] threshold and minimum count");
        for (int i = 0; i < 63; i++) applyStimulus(1'b1, 500 + i % 8, 300 + i / 8, 99);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8000, 320, 100);
        frameEnd();
        idle(5);
        checkOutput("63 px oLost", oLost, 1);
        checkOutput("63 px no valid", lastValidEdge, -1);
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 500 + i % 8, 300 + i / 8, 99);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8000, 320, 100);
        frameEnd();
        expectValid("64 px", 483, 283);
        checkOutput("64 px oLost", oLost, 0);

        $display("[TB] reset during second division");
        square(120, 220, 10);
        frameEnd();
        idle(40);
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        checkAllZero("mid reset");
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        idle(40);
        checkOutput("mid reset no valid", lastValidEdge, -1);
        square(100, 200, 10);
        frameEnd();
        expectValid("after reset", 84, 184);

        $display("[TB] randomized frames");
        for (int f = 0; f < 14; f++) begin
            n = int'($urandom_range(5, 150));
            v = int'($urandom_range(1, 50));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) v = v + int'($urandom_range(0, 3));
                applyStimulus($urandom_range(0, 4) != 0, int'($urandom_range(0, 8191)), v,
                              ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 120))
                                                          : int'($urandom_range(0, 1023)));
            end
            applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 8191)), 0,
                          int'($urandom_range(0, 200)));
            idle(int'($urandom_range(0, 80)));
        end
        idle(LATENCY + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pupil_track_ctrl.md
PUPIL_TRACK_CTRL -- requirements
Module: pupil_track_ctrl

Interface
REQ-001 The block SHALL have parameter THRESH, default 10'd100, the gray level below which a pixel counts as dark.
REQ-002 The block SHALL have parameter BOX, default 13'd40, the overlay box side in pixels.
REQ-003 The block SHALL have parameter MIN_COUNT, default 20'd64, the minimum dark-pixel count for a valid frame.
REQ-004 The block SHALL have port iCLK, input, 1, the pixel clock.
REQ-005 The block SHALL have port iRST, input, 1, the reset: asynchronous, active-low, on clock iCLK.
REQ-006 The block SHALL have port iDVAL, input, 1, the pixel-valid qualifier.
REQ-007 The block SHALL have ports iH_Cont and iV_Cont, inputs, 13 each, the current pixel column and row.
REQ-008 The block SHALL have port iGray, input, 10, the grayscale pixel value.
REQ-009 The block SHALL have ports oBoxX and oBoxY, outputs, 13 each, the box top-left corner that drives the overlay position.
REQ-010 The block SHALL have ports oValid (1-cycle pulse on box update), oLost (level, last frame had too few dark pixels), oBusy (level, divider running) and oDrop (1-cycle pulse, frame result discarded), outputs, 1 each.

Function
REQ-011 The block SHALL register iV_Cont every clock into prev_v, and SHALL detect frame end on the cycle where iV_Cont < prev_v.
REQ-012 The block SHALL accumulate a dark pixel on any cycle with iDVAL=1 and iGray < THRESH (strict): cnt+=1 (20 bits, saturating at 2^20-1), sumX+=iH_Cont and sumY+=iV_Cont (33 bits each, no wrap possible).
REQ-013 On frame end, the block SHALL copy cnt/sumX/sumY into snapshot registers, clear the accumulators, and count that cycle's pixel (if dark) into the new frame.
REQ-014 FSM states SHALL be IDLE, CHECK, DIVX, DIVY and UPDATE; oBusy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, frame end SHALL take the snapshot and go to CHECK.
REQ-016 In CHECK, if snapshot cnt < MIN_COUNT: set oLost=1, hold oBoxX/oBoxY and return to IDLE; otherwise go to DIVX.
REQ-017 DIVX SHALL perform a 33-bit by 20-bit restoring division, sumX/cnt, in exactly 33 cycles; DIVY SHALL do the same for sumY/cnt. Quotients SHALL be truncated (floor) and the low 13 bits kept.
REQ-018 In UPDATE, oBoxX SHALL be set to qX-BOX/2, or 0 if qX < BOX/2 (likewise oBoxY from qY); oLost SHALL be cleared, oValid pulsed and the FSM returned to IDLE.
REQ-019 Latency: oValid SHALL be high on exactly the 68th rising edge after the edge that registers the frame end (1 CHECK + 33 DIVX + 33 DIVY + UPDATE).
REQ-020 A frame end while not in IDLE SHALL still clear the accumulators, SHALL discard that frame's totals, SHALL pulse oDrop for 1 cycle, and SHALL leave the running division unaffected.
REQ-021 oBoxX/oBoxY SHALL change only in UPDATE, and oLost only in CHECK or UPDATE.

Reset
REQ-022 While iRST=0, the block SHALL force oBoxX=0, oBoxY=0, oValid=0, oLost=0, oBusy=0, oDrop=0, clear all accumulators and snapshots, set prev_v=0 and put the FSM in IDLE.
REQ-023 Reset asserted mid-division SHALL abort the division with no oValid; the first frame end after release SHALL start normally.

Verification
REQ-024 Dark 10x10 square (gray 0) at columns 100..109 and rows 200..209, rest gray 1023, then frame end -> oValid exactly 68 clocks later with oBoxX=84, oBoxY=184, oLost=0.
REQ-025 All-bright frame (gray 1023) -> no oValid, oLost=1 after CHECK, oBoxX/oBoxY held at previous values, oBusy back to 0 within 2 clocks.
REQ-026 Dark square at columns 0..9 and rows 0..9 -> qX=4, qY=4, clamped to oBoxX=0, oBoxY=0.
REQ-027 Second frame end 20 clocks into DIVX -> oDrop 1-cycle pulse; the first frame's result still appears at +68 clocks; the next frame accumulates from zero.
REQ-028 Dark pixel with gray exactly 100 -> not counted; gray 99 -> counted; 63 dark pixels -> oLost=1, 64 dark pixels -> oValid.
REQ-029 iRST pulsed low during DIVY -> all outputs 0 at once, no oValid; a valid frame after release -> oValid 68 clocks after its frame end.
